// File: rtl/header_check_stage.sv
// header_check_stage
//   Classifies the first beat of every packet leaving the input FIFO and
//   decides whether the packet is forwarded unchanged, redirected to the CPU
//   port paired with its source port, or dropped. Keeps the software-visible
//   exception counters.
//
// Ports
//   AXI_ACLK / AXI_RESETN     clock, asynchronous active-low reset
//   S_AXIS_*                  slave stream (beat 0 carries the header)
//   M_AXIS_*                  registered master stream, 1-cycle latency
//   reset                     software control, bit0 holds all counters at 0
//   macN_low / macN_high      MAC address of port N = {macN_high[15:0], macN_low}
//   *_count                   32-bit wrapping event counters
module header_check_stage #(
    parameter int C_S_AXI_DATA_WIDTH   = 32,
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int SRC_PORT_POS         = 16,
    parameter int DST_PORT_POS         = 24
) (
    input  logic                              AXI_ACLK,
    input  logic                              AXI_RESETN,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    input  logic                              S_AXIS_TLAST,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
    output logic                              M_AXIS_TVALID,
    input  logic                              M_AXIS_TREADY,
    output logic                              M_AXIS_TLAST,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     reset,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac0_low,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac0_high,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac1_low,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac1_high,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac2_low,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac2_high,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac3_low,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     mac3_high,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     wrong_mac_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     non_ip_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     dropped_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     bad_ttl_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     ver_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     cpu_count
);

    typedef enum logic [1:0] {ST_HEADER, ST_PASS, ST_DROP} state_t;
    typedef enum logic [1:0] {ACT_FORWARD, ACT_CPU, ACT_DROP} action_t;

    localparam int CNT_WRONG_MAC = 0;
    localparam int CNT_NON_IP    = 1;
    localparam int CNT_DROPPED   = 2;
    localparam int CNT_BAD_TTL   = 3;
    localparam int CNT_VER       = 4;
    localparam int CNT_CPU       = 5;
    localparam int CNT_NUM       = 6;
    localparam logic [C_S_AXI_DATA_WIDTH-1:0] CNT_ONE = 1;

    state_t  state, next_state;
    action_t action;

    logic                            s_hs;
    logic                            hdr_hs;
    logic                            load;
    logic                            to_cpu;
    logic [CNT_NUM-1:0]              inc;
    logic [C_S_AXI_DATA_WIDTH-1:0]   count [CNT_NUM];
    logic [C_S_AXIS_TUSER_WIDTH-1:0] user_next;
    logic [47:0]                     src_mac;

    // Header fields of beat 0
    logic [7:0]  src_field;
    logic [47:0] dst_mac;
    logic [15:0] ethertype;
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [7:0]  ttl;
    logic [7:0]  protocol;

    assign src_field = S_AXIS_TUSER[SRC_PORT_POS +: 8];
    assign dst_mac   = S_AXIS_TDATA[255:208];
    assign ethertype = S_AXIS_TDATA[159:144];
    assign version   = S_AXIS_TDATA[143:140];
    assign ihl       = S_AXIS_TDATA[139:136];
    assign ttl       = S_AXIS_TDATA[79:72];
    assign protocol  = S_AXIS_TDATA[71:64];

    // Dropped packets are swallowed at full rate; otherwise a standard
    // one-deep register slice.
    assign S_AXIS_TREADY = (state == ST_DROP) ? 1'b1 : (~M_AXIS_TVALID | M_AXIS_TREADY);
    assign s_hs          = S_AXIS_TVALID & S_AXIS_TREADY;
    assign hdr_hs        = s_hs & (state == ST_HEADER);
    assign load          = s_hs & ((state == ST_PASS) | (hdr_hs & (action != ACT_DROP)));
    assign to_cpu        = hdr_hs & (action == ACT_CPU);

    // MAC of the physical port the packet came from (even bits of src field).
    always_comb begin
        src_mac = '0;
        if (src_field[0])      src_mac = {mac0_high[15:0], mac0_low};
        else if (src_field[2]) src_mac = {mac1_high[15:0], mac1_low};
        else if (src_field[4]) src_mac = {mac2_high[15:0], mac2_low};
        else if (src_field[6]) src_mac = {mac3_high[15:0], mac3_low};
    end

    // Classification rules in priority order, first match wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        action = ACT_FORWARD;
        inc    = '0;
        if (|{src_field[7], src_field[5], src_field[3], src_field[1]}) begin
            action = ACT_FORWARD;       // traffic from CPU is never inspected
        end else if (dst_mac != src_mac && dst_mac != 48'hFFFF_FFFF_FFFF) begin
            action             = ACT_DROP;
            inc[CNT_WRONG_MAC] = 1'b1;
        end else if (ethertype == 16'h0806) begin
            action       = ACT_CPU;
            inc[CNT_CPU] = 1'b1;
        end else if (ethertype != 16'h0800) begin
            action          = ACT_DROP;
            inc[CNT_NON_IP] = 1'b1;
        end else if (version != 4'd4 || ihl < 4'd5) begin
            action       = ACT_DROP;
            inc[CNT_VER] = 1'b1;
        end else if (ttl <= 8'd1) begin
            action           = ACT_CPU;
            inc[CNT_BAD_TTL] = 1'b1;
            inc[CNT_CPU]     = 1'b1;
        end else if (protocol == 8'd89) begin
            action       = ACT_CPU;
            inc[CNT_CPU] = 1'b1;
        end
        inc[CNT_DROPPED] = (action == ACT_DROP);
        if (!hdr_hs) inc = '0;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_HEADER: if (s_hs && !S_AXIS_TLAST)
                           next_state = (action == ACT_DROP) ? ST_DROP : ST_PASS;
            ST_PASS,
            ST_DROP:   if (s_hs && S_AXIS_TLAST) next_state = ST_HEADER;
            default:   next_state = ST_HEADER;
        endcase
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!AXI_RESETN) state <= ST_HEADER;
        else             state <= next_state;
    end

    // CPU redirect: destination becomes the CPU port paired with the source.
    always_comb begin
        user_next = S_AXIS_TUSER;
        if (to_cpu) user_next[DST_PORT_POS +: 8] = {src_field[6:0], 1'b0};
    end

    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        // NOTE: the data registers are reset as well because their reset value is visible on the master port.
        if (!AXI_RESETN) begin
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TSTRB  <= '0;
            M_AXIS_TUSER  <= '0;
        end else if (load) begin
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TLAST  <= S_AXIS_TLAST;
            M_AXIS_TDATA  <= S_AXIS_TDATA;
            M_AXIS_TSTRB  <= S_AXIS_TSTRB;
            M_AXIS_TUSER  <= user_next;
        end else if (M_AXIS_TREADY) begin
            M_AXIS_TVALID <= 1'b0;
        end
    end

    // Software clear is level-sensitive and wins over a same-cycle increment.
    always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
        if (!AXI_RESETN) begin
            for (int i = 0; i < CNT_NUM; i++) count[i] <= '0;
        end else if (reset[0]) begin
            for (int i = 0; i < CNT_NUM; i++) count[i] <= '0;
        end else begin
            for (int i = 0; i < CNT_NUM; i++)
                if (inc[i]) count[i] <= count[i] + CNT_ONE;
        end
    end

    assign wrong_mac_count = count[CNT_WRONG_MAC];
    assign non_ip_count    = count[CNT_NON_IP];
    assign dropped_count   = count[CNT_DROPPED];
    assign bad_ttl_count   = count[CNT_BAD_TTL];
    assign ver_count       = count[CNT_VER];
    assign cpu_count       = count[CNT_CPU];

    // Register bits with no function in this stage.
    logic unused_bits;
    assign unused_bits = ^{reset[C_S_AXI_DATA_WIDTH-1:1],
                           mac0_high[C_S_AXI_DATA_WIDTH-1:16], mac1_high[C_S_AXI_DATA_WIDTH-1:16],
                           mac2_high[C_S_AXI_DATA_WIDTH-1:16], mac3_high[C_S_AXI_DATA_WIDTH-1:16]};

endmodule

// File: tb/tb_header_check_stage.sv
module tb_header_check_stage;

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  strb;
        logic [127:0] user;
        logic         last;
    } beat_t;

    localparam logic [47:0] MAC0  = 48'h0200_0000_0010;
    localparam logic [47:0] MAC1  = 48'h0200_0000_0020;
    localparam logic [47:0] MAC2  = 48'h0200_0000_0030;
    localparam logic [47:0] MAC3  = 48'h0200_0000_0040;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] BADMC = 48'h0200_0000_0099;

    logic         AXI_ACLK = 1'b0;
    logic         AXI_RESETN = 1'b0;
    logic [255:0] S_AXIS_TDATA = '0;
    logic [31:0]  S_AXIS_TSTRB = '0;
    logic [127:0] S_AXIS_TUSER = '0;
    logic         S_AXIS_TVALID = 1'b0;
    logic         S_AXIS_TREADY;
    logic         S_AXIS_TLAST = 1'b0;
    logic [255:0] M_AXIS_TDATA;
    logic [31:0]  M_AXIS_TSTRB;
    logic [127:0] M_AXIS_TUSER;
    logic         M_AXIS_TVALID;
    logic         M_AXIS_TREADY = 1'b1;
    logic         M_AXIS_TLAST;
    logic [31:0]  reset = '0;
    logic [31:0]  mac_low [4];
    logic [31:0]  mac_high [4];
    logic [31:0]  wrong_mac_count, non_ip_count, dropped_count, bad_ttl_count, ver_count, cpu_count;

    int    errors = 0;
    int    checks = 0;
    beat_t out_q[$];
    beat_t held_beat;
    logic  held = 1'b0;
    logic  hs_seen = 1'b0;
    logic  toggle_mode = 1'b0;

    header_check_stage dut (
        .AXI_ACLK(AXI_ACLK), .AXI_RESETN(AXI_RESETN),
        .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB), .S_AXIS_TUSER(S_AXIS_TUSER),
        .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TLAST(S_AXIS_TLAST),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB), .M_AXIS_TUSER(M_AXIS_TUSER),
        .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TLAST(M_AXIS_TLAST),
        .reset(reset),
        .mac0_low(mac_low[0]), .mac0_high(mac_high[0]), .mac1_low(mac_low[1]), .mac1_high(mac_high[1]),
        .mac2_low(mac_low[2]), .mac2_high(mac_high[2]), .mac3_low(mac_low[3]), .mac3_high(mac_high[3]),
        .wrong_mac_count(wrong_mac_count), .non_ip_count(non_ip_count), .dropped_count(dropped_count),
        .bad_ttl_count(bad_ttl_count), .ver_count(ver_count), .cpu_count(cpu_count)
    );

    always #5 AXI_ACLK = ~AXI_ACLK;

    function automatic logic [255:0] make_hdr(input logic [47:0] dmac, input logic [15:0] etype,
                                              input logic [3:0] ver, input logic [3:0] ihl,
                                              input logic [7:0] ttl, input logic [7:0] proto);
        logic [255:0] d;
        d = {8{32'h5A3C_96E1}};
        d[255:208] = dmac;
        d[159:144] = etype;
        d[143:140] = ver;
        d[139:136] = ihl;
        d[79:72]   = ttl;
        d[71:64]   = proto;
        return d;
    endfunction

    function automatic logic [127:0] make_user(input logic [7:0] src, input logic [7:0] dst);
        logic [127:0] u;
        u = {4{32'h1234_5678}};
        u[23:16] = src;
        u[31:24] = dst;
        return u;
    endfunction

    // One clock: sample outputs at the falling edge, then move to 1 time unit
    // after the rising edge where the bench drives its inputs.
    task automatic tick();
        beat_t cur;
        @(negedge AXI_ACLK);
        cur = {M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TLAST};
        hs_seen = S_AXIS_TVALID && S_AXIS_TREADY;
        if (held) begin
            checks++;
            if (M_AXIS_TVALID !== 1'b1 || cur !== held_beat) begin
                errors++;
                $display("FAIL stall_stable: got valid=%b %h required valid=1 %h", M_AXIS_TVALID, cur, held_beat);
            end
        end
        if (M_AXIS_TVALID && M_AXIS_TREADY) out_q.push_back(cur);
        held      = M_AXIS_TVALID && !M_AXIS_TREADY;
        held_beat = cur;
        @(posedge AXI_ACLK);
        #1;
        M_AXIS_TREADY = toggle_mode ? !M_AXIS_TREADY : 1'b1;
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
    endtask

    task automatic send_beat(input logic [255:0] d, input logic [31:0] s, input logic [127:0] u,
                             input logic l, output int waits);
        S_AXIS_TDATA  = d;
        S_AXIS_TSTRB  = s;
        S_AXIS_TUSER  = u;
        S_AXIS_TLAST  = l;
        S_AXIS_TVALID = 1'b1;
        waits = 0;
        tick();
        while (!hs_seen && waits < 50) begin
            waits++;
            tick();
        end
        if (!hs_seen) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: got no handshake in %0d cycles required one", waits);
        end
        S_AXIS_TVALID = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge AXI_ACLK);
        #1;
        checks++;
        if ({M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b last=%b data=%h required all 0", M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA);
        end
        checks++;
        if ({wrong_mac_count, non_ip_count, dropped_count, bad_ttl_count, ver_count, cpu_count} !== '0) begin
            errors++;
            $display("FAIL reset_counters: got wrong=%0d non_ip=%0d dropped=%0d required all 0", wrong_mac_count, non_ip_count, dropped_count);
        end
        AXI_RESETN = 1'b1;
        tick();
        checks++;
        if (S_AXIS_TREADY !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b required 1", S_AXIS_TREADY);
        end
    endtask

    task automatic test_forward();
        logic [255:0] d0, d1, d2;
        logic [127:0] u0, u1;
        beat_t exp [3];
        int w;
        out_q.delete();
        d0 = make_hdr(MAC0, 16'h0800, 4'd4, 4'd5, 8'd64, 8'd6);
        u0 = make_user(8'h01, 8'h00);
        send_beat(d0, 32'hFFFF_FFFF, u0, 1'b1, w);
        checks++;
        if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== d0) begin
            errors++;
            $display("FAIL fwd_latency: got valid=%b data=%h required valid=1 data=%h", M_AXIS_TVALID, M_AXIS_TDATA, d0);
        end
        // Back-to-back 2-beat packet: broadcast dst from port 0, TTL=2 boundary
        d1 = make_hdr(BCAST, 16'h0800, 4'd4, 4'd5, 8'd2, 8'd17);
        d2 = {8{32'hDEAD_BEEF}};
        u1 = make_user(8'h01, 8'h04);
        send_beat(d1, 32'hFFFF_FFFF, u1, 1'b0, w);
        send_beat(d2, 32'h0000_0FFF, u1, 1'b1, w);
        drain(4);
        exp[0] = {d0, 32'hFFFF_FFFF, u0, 1'b1};
        exp[1] = {d1, 32'hFFFF_FFFF, u1, 1'b0};
        exp[2] = {d2, 32'h0000_0FFF, u1, 1'b1};
        checks++;
        if (out_q.size() != 3) begin
            errors++;
            $display("FAIL fwd_count: got %0d beats required 3", out_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (out_q[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL fwd_beat%0d: got %h required %h", i, out_q[i], exp[i]);
                end
            end
        end
        checks++;
        if ({wrong_mac_count, non_ip_count, dropped_count, bad_ttl_count, ver_count, cpu_count} !== '0) begin
            errors++;
            $display("FAIL fwd_counters: got wrong=%0d dropped=%0d cpu=%0d required all 0", wrong_mac_count, dropped_count, cpu_count);
        end
    endtask

    task automatic test_arp();
        logic [255:0] d;
        beat_t exp;
        int w;
        out_q.delete();
        d = make_hdr(BCAST, 16'h0806, 4'd0, 4'd0, 8'd0, 8'd0);
        send_beat(d, 32'hFFFF_FFFF, make_user(8'h10, 8'h00), 1'b1, w);
        drain(3);
        exp = {d, 32'hFFFF_FFFF, make_user(8'h10, 8'h20), 1'b1};
        checks++;
        if (out_q.size() != 1 || out_q[0] !== exp) begin
            errors++;
            $display("FAIL arp_to_cpu: got %0d beats first=%h required 1 beat %h", out_q.size(), out_q[0], exp);
        end
        checks++;
        if (cpu_count !== 32'd1) begin
            errors++;
            $display("FAIL arp_cpu_count: got %0d required 1", cpu_count);
        end
    endtask

    task automatic test_wrong_mac();
        logic [127:0] u;
        int w;
        out_q.delete();
        u = make_user(8'h01, 8'h00);
        send_beat(make_hdr(BADMC, 16'h0800, 4'd4, 4'd5, 8'd64, 8'd6), 32'hFFFF_FFFF, u, 1'b0, w);
        for (int i = 1; i < 3; i++) begin
            M_AXIS_TREADY = 1'b0;   // drop path must not depend on downstream ready
            send_beat({8{32'h0BAD_0000 + 32'(i)}}, 32'hFFFF_FFFF, u, (i == 2), w);
            checks++;
            if (w != 0) begin
                errors++;
                $display("FAIL drop_ready_beat%0d: got %0d wait cycles required 0", i, w);
            end
        end
        drain(3);
        checks++;
        if (out_q.size() != 0) begin
            errors++;
            $display("FAIL drop_no_output: got %0d beats required 0", out_q.size());
        end
        checks++;
        if ({wrong_mac_count, non_ip_count, dropped_count, bad_ttl_count, ver_count, cpu_count}
            !== {32'd1, 32'd0, 32'd1, 32'd0, 32'd0, 32'd1}) begin
            errors++;
            $display("FAIL drop_counters: got wrong=%0d dropped=%0d required wrong=1 dropped=1", wrong_mac_count, dropped_count);
        end
    endtask

    task automatic test_headers();
        logic [255:0] hv [7];
        logic [7:0]   sv [7];
        int           act [7];   // 0 forward, 1 cpu, 2 drop
        logic [127:0] eu;
        beat_t        exp;
        int           w;
        hv[0] = make_hdr(MAC1,  16'h86DD, 4'd4, 4'd5, 8'd64, 8'd6);  sv[0] = 8'h04; act[0] = 2;
        hv[1] = make_hdr(MAC1,  16'h0800, 4'd6, 4'd5, 8'd64, 8'd6);  sv[1] = 8'h04; act[1] = 2;
        hv[2] = make_hdr(MAC1,  16'h0800, 4'd4, 4'd4, 8'd64, 8'd6);  sv[2] = 8'h04; act[2] = 2;
        hv[3] = make_hdr(MAC1,  16'h0800, 4'd4, 4'd5, 8'd1,  8'd6);  sv[3] = 8'h04; act[3] = 1;
        hv[4] = make_hdr(MAC1,  16'h0800, 4'd4, 4'd5, 8'd64, 8'd89); sv[4] = 8'h04; act[4] = 1;
        hv[5] = make_hdr(MAC1,  16'h0800, 4'd4, 4'd5, 8'd2,  8'd17); sv[5] = 8'h04; act[5] = 0;
        hv[6] = make_hdr(BADMC, 16'h86DD, 4'd6, 4'd0, 8'd0,  8'd89); sv[6] = 8'h02; act[6] = 0;
        for (int i = 0; i < 7; i++) begin
            out_q.delete();
            send_beat(hv[i], 32'hFFFF_FFFF, make_user(sv[i], 8'h00), 1'b1, w);
            drain(2);
            eu = make_user(sv[i], (act[i] == 1) ? {sv[i][6:0], 1'b0} : 8'h00);
            exp = {hv[i], 32'hFFFF_FFFF, eu, 1'b1};
            checks++;
            if (act[i] == 2 && out_q.size() != 0) begin
                errors++;
                $display("FAIL hdr%0d_drop: got %0d beats required 0", i, out_q.size());
            end else if (act[i] != 2 && (out_q.size() != 1 || out_q[0] !== exp)) begin
                errors++;
                $display("FAIL hdr%0d_out: got %0d beats first=%h required %h", i, out_q.size(), out_q[0], exp);
            end
        end
        checks++;
        if ({wrong_mac_count, non_ip_count, dropped_count, bad_ttl_count, ver_count, cpu_count}
            !== {32'd1, 32'd1, 32'd4, 32'd1, 32'd2, 32'd3}) begin
            errors++;
            $display("FAIL hdr_counters: got %0d %0d %0d %0d %0d %0d required 1 1 4 1 2 3",
                     wrong_mac_count, non_ip_count, dropped_count, bad_ttl_count, ver_count, cpu_count);
        end
    endtask

    task automatic test_back_to_back();
        beat_t exp [5];
        logic [127:0] u;
        int w;
        out_q.delete();
        u = make_user(8'h40, 8'h00);
        exp[0] = {make_hdr(MAC3, 16'h0800, 4'd4, 4'd5, 8'd64, 8'd6), 32'hFFFF_FFFF, u, 1'b0};
        for (int i = 1; i < 5; i++)
            exp[i] = {{8{32'hC0FF_EE00 + 32'(i)}}, (i == 4) ? 32'h0000_00FF : 32'hFFFF_FFFF, u, (i == 4)};
        toggle_mode = 1'b1;
        for (int i = 0; i < 5; i++) send_beat(exp[i].data, exp[i].strb, exp[i].user, exp[i].last, w);
        drain(8);
        toggle_mode = 1'b0;
        drain(2);
        checks++;
        if (out_q.size() != 5) begin
            errors++;
            $display("FAIL bp_count: got %0d beats required 5", out_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (out_q[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL bp_beat%0d: got %h required %h", i, out_q[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [255:0] d;
        logic [127:0] u;
        beat_t exp;
        int w;
        u = make_user(8'h04, 8'h00);
        send_beat(make_hdr(MAC1, 16'h0800, 4'd4, 4'd5, 8'd64, 8'd6), 32'hFFFF_FFFF, u, 1'b0, w);
        send_beat({8{32'h1111_2222}}, 32'hFFFF_FFFF, u, 1'b0, w);
        S_AXIS_TDATA  = {8{32'h3333_4444}};
        S_AXIS_TLAST  = 1'b1;
        S_AXIS_TVALID = 1'b1;
        #2;
        AXI_RESETN = 1'b0;
        #1;
        checks++;
        if ({M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER} !== '0) begin
            errors++;
            $display("FAIL arst_outputs: got valid=%b last=%b data=%h required all 0", M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA);
        end
        checks++;
        if ({wrong_mac_count, non_ip_count, dropped_count, bad_ttl_count, ver_count, cpu_count} !== '0) begin
            errors++;
            $display("FAIL arst_counters: got dropped=%0d cpu=%0d required 0", dropped_count, cpu_count);
        end
        S_AXIS_TVALID = 1'b0;
        @(posedge AXI_ACLK);
        #1;
        AXI_RESETN = 1'b1;
        out_q.delete();
        held = 1'b0;
        // ARP is redirected only if it is classified as beat 0
        d = make_hdr(BCAST, 16'h0806, 4'd0, 4'd0, 8'd0, 8'd0);
        send_beat(d, 32'hFFFF_FFFF, u, 1'b1, w);
        drain(3);
        exp = {d, 32'hFFFF_FFFF, make_user(8'h04, 8'h08), 1'b1};
        checks++;
        if (out_q.size() != 1 || out_q[0] !== exp || cpu_count !== 32'd1) begin
            errors++;
            $display("FAIL arst_next_pkt: got %0d beats first=%h cpu=%0d required %h cpu=1", out_q.size(), out_q[0], cpu_count, exp);
        end
    endtask

    task automatic test_counter_clear();
        logic [127:0] u;
        int w;
        u = make_user(8'h01, 8'h00);
        send_beat(make_hdr(BADMC, 16'h0800, 4'd4, 4'd5, 8'd64, 8'd6), 32'hFFFF_FFFF, u, 1'b1, w);
        drain(2);
        checks++;
        if ({wrong_mac_count, dropped_count, cpu_count} !== {32'd1, 32'd1, 32'd1}) begin
            errors++;
            $display("FAIL clr_pre: got wrong=%0d dropped=%0d cpu=%0d required 1 1 1", wrong_mac_count, dropped_count, cpu_count);
        end
        reset = 32'h1;
        send_beat(make_hdr(BADMC, 16'h0800, 4'd4, 4'd5, 8'd64, 8'd6), 32'hFFFF_FFFF, u, 1'b1, w);
        reset = 32'h0;
        drain(2);
        checks++;
        if ({wrong_mac_count, non_ip_count, dropped_count, bad_ttl_count, ver_count, cpu_count} !== '0) begin
            errors++;
            $display("FAIL clr_wins: got wrong=%0d dropped=%0d cpu=%0d required 0", wrong_mac_count, dropped_count, cpu_count);
        end
        send_beat(make_hdr(MAC0, 16'h0800, 4'd4, 4'd5, 8'd64, 8'd89), 32'hFFFF_FFFF, u, 1'b1, w);
        drain(2);
        checks++;
        if ({wrong_mac_count, dropped_count, cpu_count} !== {32'd0, 32'd0, 32'd1}) begin
            errors++;
            $display("FAIL clr_post: got wrong=%0d dropped=%0d cpu=%0d required 0 0 1", wrong_mac_count, dropped_count, cpu_count);
        end
    endtask

    initial begin
        mac_low[0] = MAC0[31:0]; mac_high[0] = {16'h0, MAC0[47:32]};
        mac_low[1] = MAC1[31:0]; mac_high[1] = {16'h0, MAC1[47:32]};
        mac_low[2] = MAC2[31:0]; mac_high[2] = {16'h0, MAC2[47:32]};
        mac_low[3] = MAC3[31:0]; mac_high[3] = {16'h0, MAC3[47:32]};
        test_reset();
        test_forward();
        test_arp();
        test_wrong_mac();
        test_headers();
        test_back_to_back();
        test_async_reset();
        test_counter_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
